player_hp_tracker: RTL and testbench



---
 rtl/player_hp_tracker_pkg.sv | 25 ++
 rtl/player_hp_tracker_if.sv | 24 ++
 rtl/player_hp_tracker_step_timer.sv | 27 ++
 rtl/player_hp_tracker.sv | 161 ++++++++++++++++
 tb/tb_player_hp_tracker.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/player_hp_tracker_pkg.sv
// Shared game types and default tuning for the player hit-point tracker.
// hp_t is also consumed by the HUD.
package player_hp_tracker_pkg;

  typedef logic [3:0] hp_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIVE,
    INV,
    DYING,
    DEAD
  } hp_state_t;

  localparam int unsigned DEF_HP_MAX      = 5;
  localparam int unsigned DEF_DMG_NORMAL  = 2;
  localparam int unsigned DEF_DMG_DEFEND  = 1;
  localparam int unsigned DEF_INV_STEPS   = 30;
  localparam int unsigned DEF_FLASH_HALF  = 4;
  localparam int unsigned DEF_DYING_STEPS = 60;

  // Wide enough for every step count used by the tracker, including regen.
  localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/player_hp_tracker_if.sv
// Game-step, hit and status signals between the game core and the hp tracker.
interface player_hp_tracker_if;
  import player_hp_tracker_pkg::*;

  logic step;
  logic start;
  logic isHit;
  logic defend;
  hp_t  hp;
  logic isInv;
  logic isVisible;
  logic isDying;
  logic isDead;

  modport master (
    output step, start, isHit, defend,
    input  hp, isInv, isVisible, isDying, isDead
  );

  modport slave (
    input  step, start, isHit, defend,
    output hp, isInv, isVisible, isDying, isDead
  );
endinterface

// File: rtl/player_hp_tracker_step_timer.sv
// Loadable down-counter advanced only on game steps; holds at zero and flags it.
module step_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/player_hp_tracker.sv
// Player hit points, post-hit invulnerability with blink, and dying/dead sequence.
// Optional HP_REGEN_EN: +1 HP after a run of hit-free ALIVE steps.
module player_hp_tracker
  import player_hp_tracker_pkg::*;
#(
  parameter int unsigned HP_MAX      = DEF_HP_MAX,
  parameter int unsigned DMG_NORMAL  = DEF_DMG_NORMAL,
  parameter int unsigned DMG_DEFEND  = DEF_DMG_DEFEND,
  parameter int unsigned INV_STEPS   = DEF_INV_STEPS,
  parameter int unsigned FLASH_HALF  = DEF_FLASH_HALF,
  parameter int unsigned DYING_STEPS = DEF_DYING_STEPS
) (
  input logic               clk,
  input logic               rst,
  player_hp_tracker_if.slave bus
);

  hp_state_t        state;
  hp_t              hp_q;
  logic             inv_q;
  logic             vis_q;
  logic             dying_q;
  logic             dead_q;
  logic [CNT_W-1:0] flash_cnt;

  hp_t              dmg;
  hp_t              hp_hit;
  logic             take_hit;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  assign take_hit = bus.step && bus.isHit && !bus.start && (state == ALIVE);

  always_comb begin
    dmg    = bus.defend ? hp_t'(DMG_DEFEND) : hp_t'(DMG_NORMAL);
    hp_hit = (hp_q <= dmg) ? '0 : hp_q - dmg;
  end

  // INV and DYING never overlap, so one timer serves both phases.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (bus.start) begin
      tmr_load = 1'b1;
    end else if (take_hit) begin
      tmr_load = 1'b1;
      tmr_val  = (hp_hit == '0) ? CNT_W'(DYING_STEPS - 1) : CNT_W'(INV_STEPS - 1);
    end
  end

  assign tmr_en = bus.step && ((state == INV) || (state == DYING));

  step_timer #(.W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (tmr_en),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

`ifdef HP_REGEN_EN
  localparam int unsigned REGEN_STEPS = 120;

  logic regen_en;
  logic regen_zero;
  logic regen_tick;
  logic regen_load;

  // A hit on the tick step reloads the timer and the regen is lost.
  assign regen_en   = bus.step && (state == ALIVE);
  assign regen_tick = regen_en && regen_zero && !bus.isHit && !bus.start;
  assign regen_load = bus.start || take_hit || regen_tick;

  step_timer #(.W(CNT_W)) u_regen_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (regen_en),
    .load     (regen_load),
    .load_val (CNT_W'(REGEN_STEPS - 1)),
    .zero     (regen_zero)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hp_q      <= hp_t'(HP_MAX);
      inv_q     <= 1'b0;
      vis_q     <= 1'b1;
      dying_q   <= 1'b0;
      dead_q    <= 1'b0;
      flash_cnt <= '0;
    end else if (bus.start) begin
      state     <= ALIVE;
      hp_q      <= hp_t'(HP_MAX);
      inv_q     <= 1'b0;
      vis_q     <= 1'b1;
      dying_q   <= 1'b0;
      dead_q    <= 1'b0;
      flash_cnt <= '0;
    end else if (bus.step) begin
      case (state)
        IDLE: ;
        ALIVE: begin
          if (bus.isHit) begin
            hp_q <= hp_hit;
            if (hp_hit == '0) begin
              state   <= DYING;
              dying_q <= 1'b1;
              vis_q   <= 1'b1;
            end else begin
              state     <= INV;
              inv_q     <= 1'b1;
              vis_q     <= 1'b0;
              flash_cnt <= '0;
            end
          end
`ifdef HP_REGEN_EN
          else if (regen_tick && hp_q < hp_t'(HP_MAX)) begin
            hp_q <= hp_q + hp_t'(1);
          end
`endif
        end
        INV: begin
          if (tmr_zero) begin
            state     <= ALIVE;
            inv_q     <= 1'b0;
            vis_q     <= 1'b1;
            flash_cnt <= '0;
          end else if (flash_cnt == CNT_W'(FLASH_HALF - 1)) begin
            vis_q     <= ~vis_q;
            flash_cnt <= '0;
          end else begin
            flash_cnt <= flash_cnt + CNT_W'(1);
          end
        end
        DYING: begin
          if (tmr_zero) begin
            state   <= DEAD;
            dying_q <= 1'b0;
            dead_q  <= 1'b1;
            vis_q   <= 1'b0;
            hp_q    <= '0;
          end
        end
        DEAD: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hp        = hp_q;
  assign bus.isInv     = inv_q;
  assign bus.isVisible = vis_q;
  assign bus.isDying   = dying_q;
  assign bus.isDead    = dead_q;

endmodule

// File: tb/tb_player_hp_tracker.sv
// Directed bench for player_hp_tracker: defaults on dut_a, heavy/zero damage on dut_b.
module tb_player_hp_tracker;
  import player_hp_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  player_hp_tracker_if bus_a ();
  player_hp_tracker_if bus_b ();

  player_hp_tracker dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  player_hp_tracker #(
    .DMG_NORMAL (7),
    .DMG_DEFEND (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  step;
    logic  start;
    logic  hit;
    logic  defend;
    hp_t   hp;
    logic  inv;
    logic  vis;
    logic  dying;
    logic  dead;
    string name;
  } vec_t;

  vec_t vecs[10];

  task automatic drive(input int sel, input logic s, input logic st, input logic h, input logic d);
    bus_a.step = 1'b0; bus_a.start = 1'b0; bus_a.isHit = 1'b0; bus_a.defend = 1'b0;
    bus_b.step = 1'b0; bus_b.start = 1'b0; bus_b.isHit = 1'b0; bus_b.defend = 1'b0;
    if (sel == 0) begin
      bus_a.step = s; bus_a.start = st; bus_a.isHit = h; bus_a.defend = d;
    end else begin
      bus_b.step = s; bus_b.start = st; bus_b.isHit = h; bus_b.defend = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int sel, input int n, input logic h, input logic d);
    for (int i = 0; i < n; i++) drive(sel, 1'b1, 1'b0, h, d);
  endtask

  task automatic chk(input int sel, input string name, input hp_t e_hp, input logic e_inv,
                     input logic e_vis, input logic e_dying, input logic e_dead);
    hp_t  a_hp;
    logic a_inv, a_vis, a_dying, a_dead;
    if (sel == 0) begin
      a_hp = bus_a.hp; a_inv = bus_a.isInv; a_vis = bus_a.isVisible;
      a_dying = bus_a.isDying; a_dead = bus_a.isDead;
    end else begin
      a_hp = bus_b.hp; a_inv = bus_b.isInv; a_vis = bus_b.isVisible;
      a_dying = bus_b.isDying; a_dead = bus_b.isDead;
    end
    checks++;
    if ({a_hp, a_inv, a_vis, a_dying, a_dead} === {e_hp, e_inv, e_vis, e_dying, e_dead}) begin
      passed++;
    end else begin
      $display("FAIL %s: got hp=%0d inv=%b vis=%b dying=%b dead=%b, expected hp=%0d inv=%b vis=%b dying=%b dead=%b",
               name, a_hp, a_inv, a_vis, a_dying, a_dead, e_hp, e_inv, e_vis, e_dying, e_dead);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, "idle_hit_ignored"};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, "start"};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, "hit_without_step"};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, "first_hit"};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, "inv_step1_hit"};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, "inv_step2"};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, "inv_step3"};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, "inv_blink_toggle"};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, "inv_no_step"};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, "inv_step5"};

    bus_a.step = 1'b0; bus_a.start = 1'b0; bus_a.isHit = 1'b0; bus_a.defend = 1'b0;
    bus_b.step = 1'b0; bus_b.start = 1'b0; bus_b.isHit = 1'b0; bus_b.defend = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(0, "reset_a", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    chk(1, "reset_b", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(0, vecs[i].step, vecs[i].start, vecs[i].hit, vecs[i].defend);
      chk(0, vecs[i].name, vecs[i].hp, vecs[i].inv, vecs[i].vis, vecs[i].dying, vecs[i].dead);
    end

    // Window: steps 6..29 still invulnerable, step 30 exits, step 31 hits again.
    steps(0, 24, 1'b1, 1'b0);
    chk(0, "inv_step29", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(0, "inv_exit_step30", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(0, "hit_step31", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk(0, "start_and_hit_in_inv", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);

    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    steps(0, 30, 1'b0, 1'b0);
    chk(0, "back_alive_hp3", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    steps(0, 30, 1'b0, 1'b0);
    chk(0, "back_alive_hp1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk(0, "defend_hit_to_dying", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    steps(0, 59, 1'b1, 1'b0);
    chk(0, "dying_step59", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk(0, "dead_step60", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    steps(0, 5, 1'b1, 1'b0);
    chk(0, "dead_hits_ignored", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk(0, "restart_from_dead", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef HP_REGEN_EN
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    steps(0, 30, 1'b0, 1'b0);
    steps(0, 119, 1'b0, 1'b0);
    chk(0, "regen_step119", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk(0, "regen_step120", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    steps(0, 30, 1'b0, 1'b0);
    steps(0, 119, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(0, "regen_dropped_by_hit", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    steps(0, 30, 1'b0, 1'b0);
    steps(0, 150, 1'b0, 1'b0);
    chk(0, "no_regen", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    drive(1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk(1, "b_start", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk(1, "b_full_block_opens_inv", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    steps(1, 30, 1'b0, 1'b0);
    chk(1, "b_inv_exit", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk(1, "b_saturating_hit", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    steps(1, 10, 1'b0, 1'b0);
    chk(1, "b_mid_dying", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk(1, "b_restart_mid_dying", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b1, 1'b0);
    steps(1, 60, 1'b0, 1'b0);
    chk(1, "b_dead", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
